// File: rtl/nes_clock_gen_if.sv
// nes_clock_gen_if
//   Control/status bundle of the NES clock-enable generator.
//   master : owner of the controls (debugger/CPU side); drives run, step,
//            resync and the divider write port, and observes the strobes.
//   slave  : the generator itself.
//
//   run      1 = free-running, 0 = paused
//   step     single-tick request while paused
//   resync   restart every channel at phase 0
//   cfg_we   divider write strobe
//   cfg_ch   channel selected by cfg_we
//   cfg_div  new divider value
//   ce       per-channel one-cycle enable strobes
//   tick     high in cycles where the counters advance
//   tick_cnt running count of ticks
interface nes_clock_gen_if #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 4,
  parameter int CH_W     = 2,
  parameter int TICK_W   = 16
);
  logic                run;
  logic                step;
  logic                resync;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_div;
  logic [CHANNELS-1:0] ce;
  logic                tick;
  logic [TICK_W-1:0]   tick_cnt;

  modport master (
    output run, step, resync, cfg_we, cfg_ch, cfg_div,
    input  ce, tick, tick_cnt
  );

  modport slave (
    input  run, step, resync, cfg_we, cfg_ch, cfg_div,
    output ce, tick, tick_cnt
  );
endinterface

// File: rtl/nes_clock_gen.sv
// nes_clock_gen
//   Clock-enable generator for the NES core. Every channel divides the
//   common tick by its own divider and emits a one-cycle, registered ce
//   strobe on each wrap. Dividers are reprogrammed through a pending
//   register that is only copied into the live divider at a wrap, at
//   resync, or straight away when the channel is disabled (div == 0), so a
//   running period is never cut short.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nes_clock_gen_if.slave: run/step/resync controls, divider write
//          port (cfg_we/cfg_ch/cfg_div), ce strobes, tick, tick_cnt
module nes_clock_gen #(
  parameter int                          CHANNELS = 3,
  parameter int                          CNT_W    = 4,
  parameter int                          CH_W     = 2,
  parameter logic [CHANNELS*CNT_W-1:0]   DIV_INIT = {4'd12, 4'd4, 4'd2},
  parameter int                          TICK_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  nes_clock_gen_if.slave bus
);

  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    div_q    [CHANNELS];
  logic [CNT_W-1:0]    pend_q   [CHANNELS];
  logic [CNT_W-1:0]    pend_nxt [CHANNELS];
  logic [CHANNELS-1:0] pend_valid_q;
  logic [CHANNELS-1:0] pend_valid_nxt;
  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] ce_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic                tick;

  // step only matters while paused; run=1 already ticks every cycle.
  assign tick = bus.run | (~bus.run & bus.step);

  // A write landing in the same cycle as the wrap is folded into the
  // pending value first, so it is the one that gets loaded at that wrap.
  // Selects at or above CHANNELS match no channel and are dropped.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i]         = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
      pend_nxt[i]       = wr_sel[i] ? bus.cfg_div : pend_q[i];
      pend_valid_nxt[i] = wr_sel[i] | pend_valid_q[i];
      wrap[i]           = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - CNT_W'(1));
      load[i]           = pend_valid_nxt[i] &&
                          (bus.resync || (tick && wrap[i]) || (div_q[i] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
        pend_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      pend_valid_q <= '0;
      ce_q         <= '0;
      tick_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Counter / strobe: resync dominates, then tick, else hold.
        if (bus.resync) begin
          cnt_q[i] <= '0;
          ce_q[i]  <= 1'b0;
        end else if (tick) begin
          if (div_q[i] == '0) begin
            cnt_q[i] <= '0;
            ce_q[i]  <= 1'b0;
          end else if (wrap[i]) begin
            cnt_q[i] <= '0;
            ce_q[i]  <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            ce_q[i]  <= 1'b0;
          end
        end else begin
          ce_q[i] <= 1'b0;
        end

        // Divider reload: the live divider only changes on a period
        // boundary (or when idle), never in the middle of a period.
        pend_q[i] <= pend_nxt[i];
        if (load[i]) begin
          div_q[i]        <= pend_nxt[i];
          pend_valid_q[i] <= 1'b0;
        end else begin
          pend_valid_q[i] <= pend_valid_nxt[i];
        end
      end

      // The resync cycle is not a tick, so a simultaneous step is lost.
      if (tick && !bus.resync) begin
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
    end
  end

  assign bus.ce       = ce_q;
  assign bus.tick     = tick;
  assign bus.tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_nes_clock_gen.sv
// tb_nes_clock_gen
//   Directed bench for nes_clock_gen with the default parameters
//   (dividers ch0=2, ch1=4, ch2=12). Inputs change and outputs are sampled
//   1 ns after each rising edge; edge numbers k count edges since the most
//   recent reset release.
module tb_nes_clock_gen;
  localparam int CHANNELS = 3;
  localparam int CNT_W    = 4;
  localparam int CH_W     = 2;
  localparam int TICK_W   = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  nes_clock_gen_if #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W), .TICK_W(TICK_W)
  ) bus ();

  nes_clock_gen #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W), .TICK_W(TICK_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over two edges, releases it 1 ns after an edge.
  task automatic do_reset(input logic run_v);
    bus.run     = run_v;
    bus.step    = 1'b0;
    bus.resync  = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    rst_n       = 1'b0;
    tick_edge();
    tick_edge();
    rst_n = 1'b1;
  endtask

  // Free-running with default dividers, all channels in phase at k=0.
  task automatic run_default(input string tag, input int n);
    logic [2:0] exp;
    for (int k = 1; k <= n; k++) begin
      tick_edge();
      exp = {(k % 12 == 0), (k % 4 == 0), (k % 2 == 0)};
      chk(tag, 32'(bus.ce), 32'(exp));
    end
  endtask

  initial begin
    logic [2:0] exp;
    n_chk = 0;
    n_err = 0;

    // 1: reset values, then default periods 2/4/12 from reset release.
    do_reset(1'b1);
    bus.run = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rst_ce", 32'(bus.ce), 32'd0);
    chk("rst_tick_cnt", 32'(bus.tick_cnt), 32'd0);
    rst_n = 1'b1;
    run_default("t1_ce", 24);
    chk("t1_tick_cnt", 32'(bus.tick_cnt), 32'd24);

    // 2: paused, three isolated step pulses.
    do_reset(1'b0);
    chk("t2_idle_tick", 32'(bus.tick), 32'd0);
    tick_edge();
    chk("t2_idle_ce", 32'(bus.ce), 32'd0);
    for (int s = 1; s <= 3; s++) begin
      bus.step = 1'b1;
      #1;
      chk("t2_tick_hi", 32'(bus.tick), 32'd1);
      tick_edge();
      bus.step = 1'b0;
      #1;
      chk("t2_tick_lo", 32'(bus.tick), 32'd0);
      chk("t2_step_ce", 32'(bus.ce), (s == 2) ? 32'd1 : 32'd0);
      tick_edge();
      chk("t2_gap_ce", 32'(bus.ce), 32'd0);
    end
    chk("t2_tick_cnt", 32'(bus.tick_cnt), 32'd3);

    // 3: ch1 reprogrammed to 6 mid-period; a write to ch3 is dropped.
    do_reset(1'b1);
    for (int k = 1; k <= 26; k++) begin
      tick_edge();
      exp = {(k % 12 == 0),
             (k == 4) || (k == 8) || ((k > 8) && ((k - 8) % 6 == 0)),
             (k % 2 == 0)};
      chk("t3_ce", 32'(bus.ce), 32'(exp));
      if (k == 5) begin
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 2'd1;
        bus.cfg_div = 4'd6;
      end else if (k == 6) begin
        bus.cfg_ch  = 2'd3;
        bus.cfg_div = 4'd1;
      end else if (k == 7) begin
        bus.cfg_we = 1'b0;
      end
    end
    chk("t3_tick_cnt", 32'(bus.tick_cnt), 32'd26);

    // 4: pending ch2=3, resync at edge 7, then 2/4/3 from a common origin.
    do_reset(1'b1);
    run_default("t4_pre_ce", 5);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'd2;
    bus.cfg_div = 4'd3;
    tick_edge();
    chk("t4_k6_ce", 32'(bus.ce), 32'd1);
    bus.cfg_we = 1'b0;
    bus.resync = 1'b1;
    chk("t4_pre_tick_cnt", 32'(bus.tick_cnt), 32'd6);
    tick_edge();
    chk("t4_resync_ce", 32'(bus.ce), 32'd0);
    chk("t4_resync_tick_cnt", 32'(bus.tick_cnt), 32'd6);
    bus.resync = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick_edge();
      exp = {(j % 3 == 0), (j % 4 == 0), (j % 2 == 0)};
      chk("t4_post_ce", 32'(bus.ce), 32'(exp));
    end
    chk("t4_post_tick_cnt", 32'(bus.tick_cnt), 32'd18);
    // resync together with a step: the step is lost.
    bus.run    = 1'b0;
    bus.step   = 1'b1;
    bus.resync = 1'b1;
    tick_edge();
    chk("t4_rs_step_ce", 32'(bus.ce), 32'd0);
    chk("t4_rs_step_tick_cnt", 32'(bus.tick_cnt), 32'd18);
    bus.resync = 1'b0;
    tick_edge();
    bus.step = 1'b0;
    chk("t4_step_after_ce", 32'(bus.ce), 32'd0);
    chk("t4_step_after_tick_cnt", 32'(bus.tick_cnt), 32'd19);

    // 5: ch0 disabled (div 0) at its next wrap, then div 1.
    do_reset(1'b1);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'd0;
    bus.cfg_div = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      tick_edge();
      chk("t5_ce0", 32'(bus.ce[0]), ((k == 2) || (k >= 12)) ? 32'd1 : 32'd0);
      bus.cfg_we = 1'b0;
      if (k == 10) begin
        bus.cfg_we  = 1'b1;
        bus.cfg_div = 4'd1;
      end
    end
    bus.run = 1'b0;
    tick_edge();
    chk("t5_paused_ce0", 32'(bus.ce[0]), 32'd0);

    // 6: async reset mid-period discards a pending ch2 write.
    do_reset(1'b1);
    run_default("t6_pre_ce", 8);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'd2;
    bus.cfg_div = 4'd5;
    tick_edge();
    bus.cfg_we = 1'b0;
    tick_edge();
    chk("t6_k10_ce", 32'(bus.ce), 32'd1);
    chk("t6_k10_tick_cnt", 32'(bus.tick_cnt), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ce", 32'(bus.ce), 32'd0);
    chk("t6_async_tick_cnt", 32'(bus.tick_cnt), 32'd0);
    tick_edge();
    rst_n = 1'b1;
    run_default("t6_post_ce", 24);
    chk("t6_post_tick_cnt", 32'(bus.tick_cnt), 32'd24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
